// File: rtl/dbg_pkg.sv
// Shared encodings for the host debug port: command codes, FSM states and
// the layout of the STATUS response word.
package dbg_pkg;

   typedef enum logic [2:0] {
      CMD_NOP      = 3'd0,
      CMD_SET_ADDR = 3'd1,
      CMD_WRITE    = 3'd2,
      CMD_READ     = 3'd3,
      CMD_HALT     = 3'd4,
      CMD_RUN      = 3'd5,
      CMD_STATUS   = 3'd6,
      CMD_ILLEGAL  = 3'd7
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RD_WAIT,
      ACK
   } state_e;

   localparam int STATUS_HALT_BIT = 7;

   function automatic logic [7:0] status_word(input logic halt);
      status_word                  = '0;
      status_word[STATUS_HALT_BIT] = halt;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Flop-chain synchronizer for signals crossing into the clk domain.
// STAGES must be 2 or more; all stages reset to 0.
module sync_ff #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/host_debug_port.sv
// Host-side debug responder: decodes 4-phase strobed commands to load/read
// program memory and to halt or release the CPU core.
module host_debug_port
   import dbg_pkg::*;
#(
   parameter int   ADDR_W        = 8,
   parameter int   SYNC_STAGES   = 2,
   parameter logic HALT_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              host_stb,
   input  logic [2:0]        host_cmd,
   input  logic [7:0]        host_din,
   output logic [7:0]        host_dout,
   output logic [7:0]        host_doe,
   output logic              host_ack,
   output logic              host_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   output logic              cpu_halt
);

   state_e            state, state_nxt;
   cmd_e              cmd_q;
   logic [7:0]        din_q;
   logic [ADDR_W-1:0] addr;
   logic              doe_q;
   logic              stb_s;
   logic              rw_blocked;

   sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_stb_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (host_stb),
      .q     (stb_s)
   );

   // Memory accesses are only legal while the CPU is held off the bus.
   assign rw_blocked = ((cmd_q == CMD_WRITE) || (cmd_q == CMD_READ)) && !cpu_halt;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      case (state)
         IDLE:    if (ena && stb_s) state_nxt = EXEC;
         EXEC: begin
            mem_we    = (cmd_q == CMD_WRITE) && cpu_halt;
            mem_re    = (cmd_q == CMD_READ) && cpu_halt;
            state_nxt = ((cmd_q == CMD_READ) && cpu_halt) ? RD_WAIT : ACK;
         end
         RD_WAIT: state_nxt = ACK;
         ACK:     if (!stb_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmd_q     <= CMD_NOP;
         din_q     <= '0;
         addr      <= '0;
         cpu_halt  <= HALT_ON_RESET;
         host_ack  <= 1'b0;
         host_err  <= 1'b0;
         host_dout <= '0;
         doe_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (ena && stb_s) begin
                  cmd_q <= cmd_e'(host_cmd);
                  din_q <= host_din;
               end
            end
            EXEC: begin
               host_ack <= !mem_re;
               host_err <= (cmd_q == CMD_ILLEGAL) || rw_blocked;
               doe_q    <= (cmd_q == CMD_STATUS) || ((cmd_q == CMD_READ) && !cpu_halt);
               if (mem_we || mem_re) addr <= addr + ADDR_W'(1);
               case (cmd_q)
                  CMD_SET_ADDR: addr      <= ADDR_W'(din_q);
                  CMD_HALT:     cpu_halt  <= 1'b1;
                  CMD_RUN:      cpu_halt  <= 1'b0;
                  CMD_STATUS:   host_dout <= status_word(cpu_halt);
                  CMD_READ:     if (!cpu_halt) host_dout <= '0;
                  default: ;
               endcase
            end
            RD_WAIT: begin
               host_dout <= mem_rdata;
               host_ack  <= 1'b1;
               doe_q     <= 1'b1;
            end
            ACK: begin
               if (!stb_s) begin
                  host_ack <= 1'b0;
                  host_err <= 1'b0;
                  doe_q    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign host_doe  = {8{doe_q}};
   assign mem_addr  = addr;
   assign mem_wdata = din_q;

endmodule

// File: doc/host_debug_port.md
Name: host_debug_port

Overview:
- On-chip responder for the host-side pin protocol. The cocotb bench and the external host are the initiator.
- Decodes strobed commands from the host, then loads and reads the CPU program memory. It also halts and releases the CPU.
- Sits between the top-level pin mux and the CPU core and program RAM. The pin mapping itself is done at the top level and is outside this block.

Parameters:
- ADDR_W, 8, program-memory address width; the address counter wraps modulo 2^ADDR_W.
- SYNC_STAGES, 2, number of flops in the host_stb synchronizer; must be 2 or more.
- HALT_ON_RESET, 1, reset value of cpu_halt.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design selected; while low, host_stb is ignored.
- host_stb  in  1  host strobe, asynchronous to clk, 4-phase request.
- host_cmd  in  3  command code; stable whenever host_stb is high.
- host_din  in  8  host write data; stable whenever host_stb is high.
- host_dout  out  8  response data.
- host_doe  out  8  output enable for host_dout (all 1s or all 0s).
- host_ack  out  1  4-phase acknowledge.
- host_err  out  1  error flag; valid while host_ack is high.
- mem_addr  out  ADDR_W  program-memory address.
- mem_wdata  out  8  program-memory write data.
- mem_we  out  1  single-cycle write pulse.
- mem_re  out  1  single-cycle read pulse; read data is returned the next cycle.
- mem_rdata  in  8  synchronous RAM read data.
- cpu_halt  out  1  holds the CPU core when high.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE and the address counter clears to 0.
  - host_ack=0, host_err=0, host_dout=0, host_doe=0, mem_we=0, mem_re=0.
  - cpu_halt=HALT_ON_RESET.
  - A transaction in flight is abandoned; the host must drop host_stb and retry.
- host_stb passes through a SYNC_STAGES-flop synchronizer (stb_s). host_cmd and host_din are sampled only in the IDLE cycle in which stb_s=1.
- FSM states are IDLE, EXEC, RD_WAIT, ACK.
  - IDLE: if ena and stb_s, latch cmd/din and go to EXEC. Otherwise stay in IDLE.
  - EXEC: perform the command for one cycle (see the command list). READ with no error goes to RD_WAIT; every other case sets host_ack=1 and goes to ACK.
  - RD_WAIT: capture mem_rdata into host_dout, set host_ack=1, go to ACK.
  - ACK: hold host_ack, host_err and host_dout. When stb_s=0, clear host_ack, host_err and host_doe, then go to IDLE.
- Latency: from the clk edge where stb_s first reads 1, host_ack rises 2 cycles later for non-READ commands and 3 cycles later for READ. After stb_s falls, host_ack falls on the next edge.
- Commands (3-bit):
  - 0 NOP: no action.
  - 1 SET_ADDR: addr <= din[ADDR_W-1:0].
  - 2 WRITE: mem_we=1, mem_wdata=din, mem_addr=addr; addr increments.
  - 3 READ: mem_re=1, mem_addr=addr; addr increments; response = mem_rdata.
  - 4 HALT: cpu_halt <= 1.
  - 5 RUN: cpu_halt <= 0.
  - 6 STATUS: host_dout={cpu_halt, 7'b0}.
  - 7: illegal; host_err=1 and no other action.
- host_doe=8'hFF from the cycle host_ack rises until it falls, for READ and STATUS only. It is 0 otherwise.
- WRITE or READ while cpu_halt=0:
  - No memory strobe and no address increment.
  - host_err=1; ACK is still returned.
  - For READ, host_dout=0 and the FSM skips RD_WAIT.
- Address increment wraps from 2^ADDR_W-1 to 0.
- If ena falls mid-transaction, the current transaction completes normally. ena only gates entry from IDLE.
- host_stb held high after ACK produces no second command. A new command requires stb_s to go low and then high again.
- mem_we and mem_re are never high in the same cycle. Each is high for exactly one cycle per command.

Decomposition:
- Package dbg_pkg holds:
  - the command encodings (CMD_NOP through CMD_ILLEGAL);
  - the FSM state enum;
  - the STATUS halt-bit position.
- One sub-module, sync_ff: a parameterized flop-chain synchronizer with async active-low reset to 0, instantiated for host_stb.

Test Plan:
- Reset release with HALT_ON_RESET=1 -> cpu_halt=1, host_ack=0, host_doe=0, addr=0.
- Load and verify:
  - Stimulus: SET_ADDR 0x10, then WRITE 0xA5, 0x3C, then SET_ADDR 0x10, then READ twice.
  - Required: host_dout=0xA5 then 0x3C; host_doe=0xFF during each READ ACK; no host_err.
- Address wrap: SET_ADDR 0xFF, WRITE 0x11, WRITE 0x22 -> RAM[0xFF]=0x11 and RAM[0x00]=0x22.
- Run-state protection: RUN, then WRITE 0x55 -> host_err=1, mem_we never asserted; STATUS then returns 0x00. HALT, then STATUS -> 0x80.
- Illegal and held strobe: cmd 7 -> host_err=1. WRITE with host_stb held high for 20 cycles -> exactly one mem_we pulse; host_ack is held until host_stb drops.
- Reset mid-READ: assert rst_n=0 in RD_WAIT -> host_ack=0 immediately; next transaction completes; ena=0 with host_stb=1 -> host_ack stays 0.
